// File: rtl/alu16_pkg.sv
// Shared definitions for the ALU16 result checker: op codes, data width, FSM states, record types.
package alu16_pkg;

  localparam int DW = 16;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COMPARE = 2'b01,
    ST_HALT    = 2'b10
  } chk_state_t;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          cin;
    logic [2:0]    op;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  typedef struct packed {
    logic [DW-1:0] res;
    logic          cout;
    logic          zero;
    logic          ovf;
  } rsp_t;

endpackage

// File: rtl/alu16_chk_fifo.sv
// Expected-operation FIFO for the ALU16 checker; full/empty/count derive from registered pointers.
module alu16_chk_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 36,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic         do_wr_s;
  logic         do_rd_s;

  assign count   = wr_ptr_r - rd_ptr_r;
  assign full    = (count == FULL_CNT);
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign do_wr_s = wr_en & ~full;
  assign do_rd_s = rd_en & ~empty;
  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

  // Storage array; contents are only observable while the FIFO is non-empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Read and write pointers with an extra wrap bit for full/empty disambiguation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_wr_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (do_rd_s) rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/alu16_result_checker.sv
// In-order ALU16 response checker with golden model, saturating pass/fail counters and sticky flags.
// Optional ALU16_CHK_HALT_ON_ERR_EN: halt on first mismatch and freeze the failing operation.
module alu16_result_checker
  import alu16_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_a,
  input  logic [15:0]      cmd_b,
  input  logic             cmd_cin,
  input  logic [2:0]       cmd_op,
  input  logic             rsp_valid,
  input  logic [15:0]      rsp_result,
  input  logic             rsp_cout,
  input  logic             rsp_zero,
  input  logic             rsp_overflow,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic             orphan,
  output logic             bad_op,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic rsp_t golden(input cmd_t c);
    logic [DW:0] sum;
    rsp_t        g;
    g   = '0;
    sum = '0;
    case (c.op)
      OP_AND: g.res = c.a & c.b;
      OP_OR:  g.res = c.a | c.b;
      OP_ADD: begin
        sum    = {1'b0, c.a} + {1'b0, c.b} + {{DW{1'b0}}, c.cin};
        g.res  = sum[DW-1:0];
        g.cout = sum[DW];
        g.ovf  = (c.a[DW-1] == c.b[DW-1]) & (g.res[DW-1] != c.a[DW-1]);
      end
      OP_SUB: begin
        sum    = {1'b0, c.a} + {1'b0, ~c.b} + {{DW{1'b0}}, 1'b1};
        g.res  = sum[DW-1:0];
        g.cout = sum[DW];
        g.ovf  = (c.a[DW-1] != c.b[DW-1]) & (g.res[DW-1] != c.a[DW-1]);
      end
      OP_SLT: g.res = {{(DW-1){1'b0}}, ($signed(c.a) < $signed(c.b))};
      default: g.res = '0;
    endcase
    g.zero = (g.res == '0);
    return g;
  endfunction

  function automatic logic op_known(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: op_known = 1'b1;
      default:                               op_known = 1'b0;
    endcase
  endfunction

  chk_state_t  state_r;
  cmd_t        stg_cmd_r;
  rsp_t        stg_rsp_r;
  cmd_t        fifo_rd_s;
  logic [CMD_W-1:0] fifo_rd_raw_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [AW:0] fifo_count_s;
  logic        push_s;
  logic        pop_s;
  logic        orphan_set_s;
  logic        halt_s;
  logic        stop_s;
  logic        eval_s;
  logic        good_s;
  logic        mism_s;
  logic        bad_s;
  rsp_t        exp_s;

  assign fifo_rd_s = cmd_t'(fifo_rd_raw_s);

  alu16_chk_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push_s),
    .wr_data ({cmd_a, cmd_b, cmd_cin, cmd_op}),
    .rd_en   (pop_s),
    .rd_data (fifo_rd_raw_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Evaluate the registered compare stage against the golden model.
  always_comb begin
    exp_s  = golden(stg_cmd_r);
    eval_s = (state_r == ST_COMPARE);
    mism_s = 1'b0;
    bad_s  = 1'b0;
    good_s = 1'b0;
    if (eval_s && op_known(stg_cmd_r.op)) begin
      mism_s = (exp_s.res != stg_rsp_r.res) | (exp_s.zero != stg_rsp_r.zero);
      if (stg_cmd_r.op == OP_ADD || stg_cmd_r.op == OP_SUB) begin
        mism_s = mism_s | (exp_s.cout != stg_rsp_r.cout) | (exp_s.ovf != stg_rsp_r.ovf);
      end else begin
        mism_s = mism_s;
      end
      good_s = ~mism_s;
    end else begin
      bad_s = eval_s;
    end
  end

`ifdef ALU16_CHK_HALT_ON_ERR_EN
  assign halt_s = (state_r == ST_HALT);
  // A response arriving alongside the first mismatch is already past the halt point.
  assign stop_s = halt_s | mism_s;
`else
  assign halt_s = 1'b0;
  assign stop_s = 1'b0;
`endif

  assign cmd_ready    = ~fifo_full_s & ~halt_s;
  assign push_s       = cmd_valid & cmd_ready;
  assign pop_s        = rsp_valid & ~fifo_empty_s & ~stop_s;
  assign orphan_set_s = rsp_valid & fifo_empty_s & ~stop_s;
  assign busy         = (fifo_count_s != '0) | (state_r == ST_COMPARE);

  // Checker FSM with compare-stage registers, counters and sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      stg_cmd_r <= '0;
      stg_rsp_r <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      err       <= 1'b0;
      orphan    <= 1'b0;
      bad_op    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE:    state_r <= pop_s ? ST_COMPARE : ST_IDLE;
`ifdef ALU16_CHK_HALT_ON_ERR_EN
        ST_COMPARE: state_r <= mism_s ? ST_HALT : (pop_s ? ST_COMPARE : ST_IDLE);
        ST_HALT:    state_r <= ST_HALT;
`else
        ST_COMPARE: state_r <= pop_s ? ST_COMPARE : ST_IDLE;
        ST_HALT:    state_r <= ST_IDLE;
`endif
        default:    state_r <= ST_IDLE;
      endcase
      if (pop_s) begin
        stg_cmd_r <= fifo_rd_s;
        stg_rsp_r <= {rsp_result, rsp_cout, rsp_zero, rsp_overflow};
      end
      if (good_s && pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
      if (mism_s && fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
      if (mism_s)       err    <= 1'b1;
      if (orphan_set_s) orphan <= 1'b1;
      if (bad_s)        bad_op <= 1'b1;
    end
  end

`ifdef ALU16_CHK_HALT_ON_ERR_EN
  logic [DW-1:0] cap_a_r;
  logic [DW-1:0] cap_b_r;
  logic [2:0]    cap_op_r;
  logic [DW-1:0] cap_exp_r;
  logic [DW-1:0] cap_act_r;

  // Freeze the first failing operation; HALT stops evaluation so later mismatches never reach here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_a_r   <= '0;
      cap_b_r   <= '0;
      cap_op_r  <= 3'b000;
      cap_exp_r <= '0;
      cap_act_r <= '0;
    end else if (mism_s) begin
      cap_a_r   <= stg_cmd_r.a;
      cap_b_r   <= stg_cmd_r.b;
      cap_op_r  <= stg_cmd_r.op;
      cap_exp_r <= exp_s.res;
      cap_act_r <= stg_rsp_r.res;
    end
  end
`endif

endmodule
